imem_loader: RTL

//  Writer side of the CPU instruction/data memory: streams a program image into RAM before the pipeline runs.

---
 rtl/loader_pkg.sv | 18 +
 rtl/loader_cksum.sv | 41 ++++
 rtl/imem_loader.sv | 137 +++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and default widths for the instruction-memory loader.
// Imported by imem_loader and loader_cksum.
package loader_pkg;

  localparam int DATA_W_C = 32;
  localparam int ADDR_W_C = 10;

  localparam logic [31:0] HALT_WORD_C = 32'hffffffff;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHK,
    S_DONE,
    S_ERR
  } state_e;

endpackage

// File: rtl/loader_cksum.sv
// Running 32-bit sum of the loaded image, compared against the trailer word.
// Only instantiated when LOADER_CHECKSUM_EN is defined.
module loader_cksum
  import loader_pkg::*;
#(
  parameter int W = DATA_W_C
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         add_i,
  input  logic [W-1:0] data_i,
  input  logic [W-1:0] cmp_i,
  output logic         match_o
);

  logic [W-1:0] sum_q;
  logic [W-1:0] sum_d;

  // clear at the start of a load, accumulate each accepted image word
  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (add_i) begin
      sum_d = sum_q + data_i;
    end
  end

  // sum register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign match_o = (sum_q == cmp_i);

endmodule

// File: rtl/imem_loader.sv
// Streams a program image into memory, then releases the CPU.
// Optional trailer checksum: define LOADER_CHECKSUM_EN.
module imem_loader
  import loader_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_C,
  parameter int                ADDR_W    = ADDR_W_C,
  parameter logic [DATA_W-1:0] HALT_WORD = HALT_WORD_C
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              cpu_run_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [ADDR_W:0]   count_o
);

  localparam logic [ADDR_W:0] LAST_C = {1'b0, {ADDR_W{1'b1}}};

  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              run_q, run_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic busy;
  logic accept;
  logic is_halt;
  logic ck_match;

  assign busy    = (state_q == S_LOAD) | (state_q == S_CHK);
  assign accept  = in_valid_i & busy;
  assign is_halt = (in_data_i == HALT_WORD);

`ifdef LOADER_CHECKSUM_EN
  loader_cksum #(
    .W (DATA_W)
  ) u_cksum (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (start_i & ~busy),
    .add_i   (accept & (state_q == S_LOAD)),
    .data_i  (in_data_i),
    .cmp_i   (in_data_i),
    .match_o (ck_match)
  );
`else
  assign ck_match = 1'b0;
`endif

  // next state, address counter and registered write port
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = cnt_q[ADDR_W-1:0];
          wdata_d = in_data_i;
          cnt_d   = cnt_q + 1'b1;
          if (is_halt) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
`endif
          end else if (cnt_q == LAST_C) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_CHK: begin
        if (accept) begin
          state_d = ck_match ? S_DONE : S_ERR;
          err_d   = ~ck_match;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    run_d = (state_q == S_DONE) & ~start_i;
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      run_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      run_q   <= run_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign in_ready_o  = busy;
  assign busy_o      = busy;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign cpu_run_o   = run_q;
  assign err_o       = err_q;
  assign count_o     = cnt_q;

endmodule
